// File: rtl/interrupt_bank_pkg.sv
// interrupt_pkg: shared types, default widths and helpers for interrupt_bank
// Contents: coal_state_e (coalescing FSM states), DefCntW/DefTmrW, IRQ_ID_W().
package interrupt_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, FIRE} coal_state_e;
    localparam int DefCntW = 8;
    localparam int DefTmrW = 16;
    // Width of a channel index; never narrower than one bit.
    function automatic int IRQ_ID_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/interrupt_bank_if.sv
// interrupt_bank_if: CSR-side signal bundle of the interrupt bank
// slave  (bank side): irq_i, irq_force_i, clr_i, sts_ena_i, sig_ena_i,
//                     coal_thresh_i, coal_timeout_i in; sts_o, pending_o,
//                     irq_id_o, irq_id_valid_o, irq_o out.
// master (CSR side):  the same signals with opposite directions.
interface interrupt_bank_if import interrupt_pkg::*; #(
    parameter int NumIrq = 8,
    parameter int CntW = DefCntW,
    parameter int TmrW = DefTmrW
);
    logic [NumIrq-1:0] irq_i, irq_force_i, clr_i, sts_ena_i, sig_ena_i;
    logic [NumIrq-1:0] sts_o, pending_o;
    logic [IRQ_ID_W(NumIrq)-1:0] irq_id_o;
    logic irq_id_valid_o, irq_o;
    logic [CntW-1:0] coal_thresh_i;
    logic [TmrW-1:0] coal_timeout_i;
    modport slave (
        input irq_i, irq_force_i, clr_i, sts_ena_i, sig_ena_i, coal_thresh_i, coal_timeout_i,
        output sts_o, pending_o, irq_id_o, irq_id_valid_o, irq_o
    );
    modport master (
        output irq_i, irq_force_i, clr_i, sts_ena_i, sig_ena_i, coal_thresh_i, coal_timeout_i,
        input sts_o, pending_o, irq_id_o, irq_id_valid_o, irq_o
    );
endinterface

// File: rtl/interrupt_coalesce.sv
// interrupt_coalesce: holds back the aggregated IRQ until enough new events or a timeout
// Ports: clk_i, rst_ni (async, active-low), pending_i (masked status),
//        thresh_i (event threshold), timeout_i (cycles), irq_o (registered IRQ).
module interrupt_coalesce import interrupt_pkg::*; #(
    parameter int NumIrq = 8,
    parameter int CntW = DefCntW,
    parameter int TmrW = DefTmrW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumIrq-1:0] pending_i,
    input  logic [CntW-1:0]   thresh_i,
    input  logic [TmrW-1:0]   timeout_i,
    output logic              irq_o
);
    coal_state_e state_d, state_q;
    logic [NumIrq-1:0] pend_d, pend_q;
    logic [CntW-1:0] cnt_d, cnt_q, newset, cnt_sat;
    logic [CntW:0] cnt_sum;
    logic [TmrW-1:0] tmr_d, tmr_q, tmr_sat;
    logic irq_d, irq_q, any;
    always_comb begin
        newset = '0;
        for (int i = 0; i < NumIrq; i++)
            if (pending_i[i] && !pend_q[i] && newset != '1) newset = newset + CntW'(1);
        any = |pending_i;
        pend_d = pending_i;
        cnt_sum = {1'b0, cnt_q} + {1'b0, newset};
        cnt_sat = cnt_sum[CntW] ? '1 : cnt_sum[CntW-1:0];
        tmr_sat = (tmr_q == '1) ? tmr_q : tmr_q + TmrW'(1);
        state_d = state_q;
        cnt_d = '0;
        tmr_d = '0;
        case (state_q)
            IDLE: begin
                cnt_d = newset;
                state_d = any ? ACCUM : IDLE;
            end
            // Threshold sees this cycle's new events; timeout compares the elapsed count,
            // so threshold<=1 or timeout=0 fires one cycle after entry.
            ACCUM: begin
                cnt_d = any ? cnt_sat : '0;
                tmr_d = any ? tmr_sat : '0;
                state_d = !any ? IDLE : (cnt_sat >= thresh_i || tmr_q >= timeout_i) ? FIRE : ACCUM;
            end
            FIRE: state_d = any ? FIRE : IDLE;
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == FIRE);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q <= '0;
            cnt_q <= '0;
            tmr_q <= '0;
            irq_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            cnt_q <= cnt_d;
            tmr_q <= tmr_d;
            irq_q <= irq_d;
        end
    end
    assign irq_o = irq_q;
endmodule

// File: rtl/interrupt_bank.sv
// interrupt_bank: multi-channel IRQ status bank with priority index and aggregated IRQ
// Ports: clk_i, rst_ni (async, active-low), bus (interrupt_bank_if.slave).
// Define INTERRUPT_BANK_COALESCE_EN to register irq_o through event coalescing;
// otherwise irq_o = |pending_o and the coal_* inputs are ignored.
module interrupt_bank import interrupt_pkg::*; #(
    parameter int NumIrq = 8,
    parameter logic [NumIrq-1:0] EdgeMask = {NumIrq{1'b1}},
    parameter int CntW = DefCntW,
    parameter int TmrW = DefTmrW
) (
    input logic clk_i,
    input logic rst_ni,
    interrupt_bank_if.slave bus
);
    localparam int IdW = IRQ_ID_W(NumIrq);
    logic [NumIrq-1:0] src, trg, src_d, src_q, sts_d, sts_q, pending;
    logic [IdW-1:0] irq_id;
    always_comb begin
        src = bus.irq_i | bus.irq_force_i;
        trg = (EdgeMask & src & ~src_q) | (~EdgeMask & src);
        src_d = src;
        // A trigger beats a same-cycle clear; a blocked trigger leaves the bit alone.
        sts_d = (trg & bus.sts_ena_i) | (sts_q & ~bus.clr_i);
        pending = sts_q & bus.sig_ena_i;
        irq_id = '0;
        for (int i = NumIrq - 1; i >= 0; i--)
            if (pending[i]) irq_id = IdW'(i);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= '0;
            sts_q <= '0;
        end else begin
            src_q <= src_d;
            sts_q <= sts_d;
        end
    end
    assign bus.sts_o = sts_q;
    assign bus.pending_o = pending;
    assign bus.irq_id_o = irq_id;
    assign bus.irq_id_valid_o = |pending;
`ifdef INTERRUPT_BANK_COALESCE_EN
    interrupt_coalesce #(.NumIrq(NumIrq), .CntW(CntW), .TmrW(TmrW)) u_coal (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .pending_i(pending),
        .thresh_i(bus.coal_thresh_i),
        .timeout_i(bus.coal_timeout_i),
        .irq_o(bus.irq_o)
    );
`else
    logic unused_coal;
    assign unused_coal = ^{bus.coal_thresh_i, bus.coal_timeout_i};
    assign bus.irq_o = |pending;
`endif
endmodule
